// File: rtl/avsddac_pkg.sv
// Shared constants and state encoding for the avsddac sample sequencer.
package avsddac_pkg;

  localparam int unsigned DAC_DW         = 10;
  localparam int unsigned DAC_RESET_CODE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/avsddac_code_fifo.sv
// Small synchronous code FIFO with flush and occupancy level; head is read combinationally.
module avsddac_code_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/avsddac_sample_sequencer.sv
// Paces codes from the core FIFO onto the DAC D bus at a programmable, jitter-free sample rate.
module avsddac_sample_sequencer
  import avsddac_pkg::*;
#(
  parameter int unsigned     DW         = DAC_DW,
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     DIVW       = 16,
  parameter logic [DW-1:0]   RESET_CODE = DW'(DAC_RESET_CODE),
  localparam int unsigned    LW         = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [DW-1:0]   dac_d,
  output logic            sample_strobe,
  output logic [LW-1:0]   fifo_level,
  output logic            underrun,
  input  logic            underrun_clr
);

  seq_state_e      state_q;
  seq_state_e      state_d;
  logic [DIVW-1:0] cnt_q;
  logic [DIVW-1:0] cnt_d;
  logic [DIVW-1:0] period_q;
  logic [DIVW-1:0] period_d;
  logic            tick;
  logic            pop;
  logic            underrun_set;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_head;

  assign in_ready     = !fifo_full && !flush;
  assign pop          = tick && !fifo_empty && !flush;
  assign underrun_set = tick && (fifo_empty || flush);

  avsddac_code_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .flush (flush),
    .wdata (in_data),
    .rdata (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  // Divider: the period is relatched only at a wrap so div edits never shorten a sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    tick     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d  = RUN;
          period_d = div;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == period_q) begin
          tick     = 1'b1;
          cnt_d    = '0;
          period_d = div;
        end else begin
          cnt_d = cnt_q + DIVW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_d         <= RESET_CODE;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= tick;
      if (pop) begin
        dac_d <= fifo_head;
      end
      if (underrun_set) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avsddac_sample_sequencer.sv
// Directed bench for the avsddac sample sequencer with hand-computed expectations.
module tb_avsddac_sample_sequencer;

  localparam int unsigned DW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIVW  = 16;
  localparam int unsigned LW    = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [DIVW-1:0] div;
  logic            flush;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [DW-1:0]   dac_d;
  logic            sample_strobe;
  logic [LW-1:0]   fifo_level;
  logic            underrun;
  logic            underrun_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avsddac_sample_sequencer #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .DIVW       (DIVW),
    .RESET_CODE (10'h000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .div           (div),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .dac_d         (dac_d),
    .sample_strobe (sample_strobe),
    .fifo_level    (fifo_level),
    .underrun      (underrun),
    .underrun_clr  (underrun_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land just after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    div          = '0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    underrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac_d", 32'(dac_d), 32'h000);
    chk("rst_strobe", 32'(sample_strobe), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;

    // Three codes paced by div=3: strobes on cycles 5, 9, 13 after enabling.
    div      = 16'd3;
    in_valid = 1'b1;
    in_data  = 10'h000; cyc();
    in_data  = 10'h3FF; cyc();
    in_data  = 10'h200; cyc();
    in_valid = 1'b0;
    chk("t2_level3", 32'(fifo_level), 32'h3);
    en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      chk($sformatf("t2_strobe_k%0d", k), 32'(sample_strobe),
          32'((k == 5) || (k == 9) || (k == 13)));
      if (k == 5)  chk("t2_dac_000", 32'(dac_d), 32'h000);
      if (k == 9)  chk("t2_dac_3ff", 32'(dac_d), 32'h3FF);
      if (k == 13) chk("t2_dac_200", 32'(dac_d), 32'h200);
    end
    chk("t2_level0", 32'(fifo_level), 32'h0);
    en = 1'b0;
    cyc();
    chk("t2_idle_dac", 32'(dac_d), 32'h200);
    chk("t2_idle_underrun", 32'(underrun), 32'h0);

    // div=0 with an empty FIFO: underrun on first tick, set wins over clear.
    div = 16'd0;
    en  = 1'b1;
    cyc();
    chk("t3_pre_underrun", 32'(underrun), 32'h0);
    cyc();
    chk("t3_strobe", 32'(sample_strobe), 32'h1);
    chk("t3_underrun", 32'(underrun), 32'h1);
    chk("t3_dac_held", 32'(dac_d), 32'h200);
    underrun_clr = 1'b1;
    cyc();
    chk("t3_set_wins", 32'(underrun), 32'h1);
    en = 1'b0;
    cyc();
    chk("t3_cleared", 32'(underrun), 32'h0);
    chk("t3_idle_strobe", 32'(sample_strobe), 32'h0);
    underrun_clr = 1'b0;

    // div 3->7 mid-period: current period 4, following periods 8.
    div = 16'd3;
    en  = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      if (k == 2) div = 16'd7;
      chk($sformatf("t5_strobe_k%0d", k), 32'(sample_strobe),
          32'((k == 5) || (k == 13) || (k == 21)));
    end
    chk("t5_underrun", 32'(underrun), 32'h1);
    chk("t5_dac_held", 32'(dac_d), 32'h200);
    en = 1'b0;
    cyc();
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    chk("t5_clr", 32'(underrun), 32'h0);

    // Fill to DEPTH; a pop while full does not admit a same-cycle push.
    div      = 16'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 10'(32'h11 * (i + 1));
      cyc();
      chk($sformatf("t4_level_%0d", i + 1), 32'(fifo_level), 32'(i + 1));
    end
    in_data = 10'h055;
    chk("t4_full_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("t4_full_level", 32'(fifo_level), 32'h4);
    en = 1'b1;
    cyc();
    chk("t4_run_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("t4_pop_strobe", 32'(sample_strobe), 32'h1);
    chk("t4_pop_dac", 32'(dac_d), 32'h011);
    chk("t4_no_push", 32'(fifo_level), 32'h3);
    chk("t4_ready_back", 32'(in_ready), 32'h1);
    en = 1'b0;
    cyc();
    chk("t4_push_level", 32'(fifo_level), 32'h4);
    chk("t4_idle_strobe", 32'(sample_strobe), 32'h0);
    in_valid = 1'b0;

    // Drain two codes, then flush on a tick with level=2.
    en = 1'b1;
    cyc();
    cyc();
    chk("t6_dac_22", 32'(dac_d), 32'h022);
    cyc();
    chk("t6_dac_33", 32'(dac_d), 32'h033);
    chk("t6_level2", 32'(fifo_level), 32'h2);
    chk("t6_pre_underrun", 32'(underrun), 32'h0);
    flush = 1'b1;
    #1;
    chk("t6_flush_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("t6_level0", 32'(fifo_level), 32'h0);
    chk("t6_dac_held", 32'(dac_d), 32'h033);
    chk("t6_strobe", 32'(sample_strobe), 32'h1);
    chk("t6_underrun", 32'(underrun), 32'h1);
    flush = 1'b0;
    en    = 1'b0;
    cyc();

    // Asynchronous reset mid-RUN with three codes still queued.
    in_valid = 1'b1;
    in_data  = 10'h123; cyc();
    in_data  = 10'h0AB; cyc();
    in_data  = 10'h3C3; cyc();
    in_data  = 10'h155; cyc();
    in_valid = 1'b0;
    en       = 1'b1;
    cyc();
    cyc();
    chk("t1_dac_pre", 32'(dac_d), 32'h123);
    chk("t1_level_pre", 32'(fifo_level), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_dac", 32'(dac_d), 32'h000);
    chk("t1_rst_level", 32'(fifo_level), 32'h0);
    chk("t1_rst_underrun", 32'(underrun), 32'h0);
    chk("t1_rst_strobe", 32'(sample_strobe), 32'h0);
    chk("t1_rst_ready", 32'(in_ready), 32'h1);
    en = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t1_post_dac", 32'(dac_d), 32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
